// File: rtl/ifu_prefetch.sv
// ifu_prefetch: decoupled instruction fetch with a credit-limited
// request channel, in-order response tracking and a prefetch FIFO.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   o_imem_req_*       word-address fetch request (valid/ready)
//   i_imem_rsp_*       in-order instruction responses, no backpressure
//   o_inst*, i_inst_ready  FIFO head {inst, pc} to the decoder
//   i_redirect*        flush and restart fetch at a new word address
module ifu_prefetch #(
  parameter int unsigned       ADDR_W   = 30,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              o_imem_req_valid,
  output logic [ADDR_W-1:0] o_imem_req_addr,
  input  logic              i_imem_req_ready,
  input  logic              i_imem_rsp_valid,
  input  logic [31:0]       i_imem_rsp_data,
  output logic              o_inst_valid,
  output logic [31:0]       o_inst,
  output logic [ADDR_W-1:0] o_inst_pc,
  input  logic              i_inst_ready,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     live_q, live_d;
  logic [CW-1:0]     kill_q, kill_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;

  logic [31:0]       buf_data_q [DEPTH];
  logic [ADDR_W-1:0] buf_pc_q   [DEPTH];

  logic [CW-1:0] credit_used;
  logic          credit_ok;
  logic          req_fire;
  logic          rsp_drop;
  logic          rsp_take;
  logic          rsp_used;
  logic          push;
  logic          pop;

  // Every FIFO slot is reserved by a live request or a stored entry,
  // so a response can never find the FIFO full.
  assign credit_used = live_q + count_q;
  assign credit_ok   = credit_used < DEPTH_C;

  assign o_imem_req_valid = rst_n && credit_ok;
  assign o_imem_req_addr  = pc_q;

  assign o_inst_valid = (count_q != '0);
  assign o_inst       = buf_data_q[rd_ptr_q];
  assign o_inst_pc    = buf_pc_q[rd_ptr_q];

  assign req_fire = o_imem_req_valid && i_imem_req_ready;
  assign pop      = o_inst_valid && i_inst_ready;

  // Old-stream responses are consumed first; a response with nothing
  // outstanding is ignored entirely.
  assign rsp_drop = i_imem_rsp_valid && (kill_q != '0);
  assign rsp_take = i_imem_rsp_valid && (kill_q == '0)
                    && (live_q != '0);
  assign rsp_used = rsp_drop || rsp_take;

  // A response in the redirect cycle belongs to the old stream.
  assign push = rsp_take && !i_redirect;

  always_comb begin
    pc_d     = pc_q + ADDR_W'(req_fire);
    rsp_pc_d = rsp_pc_q + ADDR_W'(push);
    live_d   = live_q + CW'(req_fire) - CW'(rsp_take);
    kill_d   = kill_q - CW'(rsp_drop);
    count_d  = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    if (i_redirect) begin
      pc_d     = i_redirect_pc;
      rsp_pc_d = i_redirect_pc;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      live_d   = '0;
      // Everything in flight, including a request accepted this
      // cycle, now belongs to the dead stream.
      kill_d   = kill_q + live_q + CW'(req_fire)
                 - CW'(rsp_used);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      count_q  <= '0;
      live_q   <= '0;
      kill_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      count_q  <= count_d;
      live_q   <= live_d;
      kill_q   <= kill_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: count_q gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data_q[wr_ptr_q] <= i_imem_rsp_data;
      buf_pc_q[wr_ptr_q]   <= rsp_pc_q;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: scoreboard bench for ifu_prefetch with a
// fixed-latency in-order memory model and a decoder-side monitor.
module tb_ifu_prefetch;

  localparam int AW = 30;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic [AW-1:0] req_addr;
  logic          req_ready;
  logic          rsp_valid;
  logic [31:0]   rsp_data;
  logic          inst_valid;
  logic [31:0]   inst;
  logic [AW-1:0] inst_pc;
  logic          inst_ready;
  logic          redirect;
  logic [AW-1:0] redirect_pc;

  always #5 clk = ~clk;

  ifu_prefetch #(
    .ADDR_W(AW),
    .RESET_PC(30'h10),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .o_imem_req_valid(req_valid),
    .o_imem_req_addr(req_addr),
    .i_imem_req_ready(req_ready),
    .i_imem_rsp_valid(rsp_valid),
    .i_imem_rsp_data(rsp_data),
    .o_inst_valid(inst_valid),
    .o_inst(inst),
    .o_inst_pc(inst_pc),
    .i_inst_ready(inst_ready),
    .i_redirect(redirect),
    .i_redirect_pc(redirect_pc)
  );

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } mreq_t;

  int            checks = 0;
  int            errors = 0;
  int            pops = 0;
  int            lat = 1;
  bit            rdy_toggle = 1'b0;
  int            mcyc = 0;
  mreq_t         mq[$];
  logic [AW-1:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return {2'b10, a} ^ 32'h5a5a_0f0f;
  endfunction

  task automatic push_exp(input logic [AW-1:0] start, input int n);
    logic [AW-1:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(a);
      a = a + 1'b1;
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Memory: answers each accepted request exactly lat cycles later.
  initial begin
    mreq_t m;
    req_ready = 1'b1;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      mcyc++;
      req_ready = rdy_toggle ? mcyc[0] : 1'b1;
      if (mq.size() != 0 && mq[0].due == mcyc) begin
        m = mq.pop_front();
        rsp_valid = 1'b1;
        rsp_data  = mem_word(m.addr);
      end else begin
        rsp_valid = 1'b0;
        rsp_data  = '0;
      end
      @(negedge clk);
      if (!rst_n) mq.delete();
      else if (req_valid && req_ready)
        mq.push_back('{req_addr, mcyc + lat});
    end
  end

  // Decoder side: every consumed head is popped from the scoreboard.
  initial begin
    logic [AW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && inst_valid && inst_ready) begin
        pops++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: got pc %h, want nothing", inst_pc);
        end else begin
          e = exp_q.pop_front();
          if (inst_pc !== e) begin
            errors++;
            $display("FAIL sb_pc: got %h want %h", inst_pc, e);
          end
          checks++;
          if (inst !== mem_word(e)) begin
            errors++;
            $display("FAIL sb_data: got %h want %h", inst, mem_word(e));
          end
        end
      end
    end
  end

  task automatic do_reset(input int l, input bit tog);
    next_cyc();
    rst_n = 1'b0;
    inst_ready = 1'b0;
    redirect = 1'b0;
    lat = l;
    rdy_toggle = tog;
    next_cyc();
    next_cyc();
    exp_q.delete();
    next_cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) next_cyc();
    @(negedge clk);
    checks++;
    if (req_valid !== 1'b0) begin
      errors++; $display("FAIL rst_req_valid: got %b want 0", req_valid);
    end
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid);
    end
    checks++;
    if (req_addr !== 30'h10) begin
      errors++; $display("FAIL rst_addr: got %h want 10", req_addr);
    end
  endtask

  task automatic test_stream();
    logic [AW-1:0] nreq;
    int idle;
    nreq = 30'h10;
    idle = 0;
    do_reset(1, 1'b0);
    inst_ready = 1'b1;
    push_exp(30'h10, 64);
    for (int c = 0; c < 22; c++) begin
      if (c > 0) next_cyc();
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (req_valid !== 1'b1) begin
          errors++; $display("FAIL first_req: got %b want 1", req_valid);
        end
      end
      if (c == 1) begin
        checks++;
        if (inst_valid !== 1'b0) begin
          errors++; $display("FAIL no_fallthru: got %b want 0", inst_valid);
        end
      end
      if (c == 2) begin
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 30'h10) begin
          errors++;
          $display("FAIL first_inst: got v=%b pc=%h want v=1 pc=10",
                   inst_valid, inst_pc);
        end
      end
      if (c >= 2 && !inst_valid) idle++;
      if (req_valid && req_ready) begin
        checks++;
        if (req_addr !== nreq) begin
          errors++; $display("FAIL req_seq: got %h want %h", req_addr, nreq);
        end
        nreq = nreq + 1'b1;
      end
    end
    checks++;
    if (idle != 0) begin
      errors++; $display("FAIL stream_rate: got %0d idle want 0", idle);
    end
    checks++;
    if (nreq !== 30'h10 + 30'd22) begin
      errors++; $display("FAIL req_rate: got %h want %h", nreq, 30'h26);
    end
  endtask

  task automatic test_backpressure();
    int fires;
    int p0;
    fires = 0;
    do_reset(1, 1'b0);
    inst_ready = 1'b0;
    push_exp(30'h10, 40);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) next_cyc();
      @(negedge clk);
      if (req_valid && req_ready) fires++;
    end
    checks++;
    if (fires != 4) begin
      errors++; $display("FAIL bp_fires: got %0d want 4", fires);
    end
    checks++;
    if (req_valid !== 1'b0) begin
      errors++; $display("FAIL bp_req_valid: got %b want 0", req_valid);
    end
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 30'h10) begin
      errors++;
      $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=10",
               inst_valid, inst_pc);
    end
    next_cyc();
    inst_ready = 1'b1;
    p0 = pops;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      next_cyc();
    end
    checks++;
    if (pops - p0 != 8) begin
      errors++; $display("FAIL bp_drain: got %0d pops want 8", pops - p0);
    end
  endtask

  task automatic test_redirect_inflight();
    int early;
    early = 0;
    do_reset(3, 1'b0);
    inst_ready = 1'b0;
    next_cyc();
    next_cyc();
    redirect = 1'b1;
    redirect_pc = 30'h200;
    exp_q.delete();
    push_exp(30'h200, 40);
    @(negedge clk);
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 30'h12) begin
      errors++;
      $display("FAIL rd_old_req: got v=%b a=%h want v=1 a=12",
               req_valid, req_addr);
    end
    next_cyc();
    redirect = 1'b0;
    inst_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++; $display("FAIL rd_flush: got %b want 0", inst_valid);
    end
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 30'h200) begin
      errors++;
      $display("FAIL rd_new_req: got v=%b a=%h want v=1 a=200",
               req_valid, req_addr);
    end
    for (int c = 4; c < 7; c++) begin
      next_cyc();
      @(negedge clk);
      if (inst_valid) early++;
    end
    checks++;
    if (early != 0) begin
      errors++; $display("FAIL rd_drop: got %0d early valids want 0", early);
    end
    next_cyc();
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 30'h200) begin
      errors++;
      $display("FAIL rd_first: got v=%b pc=%h want v=1 pc=200",
               inst_valid, inst_pc);
    end
    repeat (12) next_cyc();
  endtask

  task automatic test_redirect_coincident();
    do_reset(1, 1'b0);
    inst_ready = 1'b1;
    push_exp(30'h10, 4);
    push_exp(30'h300, 40);
    repeat (5) next_cyc();
    redirect = 1'b1;
    redirect_pc = 30'h300;
    @(negedge clk);
    checks++;
    if (req_valid !== 1'b1 || rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL co_setup: got req=%b rsp=%b want 1 1",
               req_valid, rsp_valid);
    end
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 30'h13) begin
      errors++;
      $display("FAIL co_pop: got v=%b pc=%h want v=1 pc=13",
               inst_valid, inst_pc);
    end
    next_cyc();
    redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++; $display("FAIL co_empty: got %b want 0", inst_valid);
    end
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 30'h300) begin
      errors++;
      $display("FAIL co_new_req: got v=%b a=%h want v=1 a=300",
               req_valid, req_addr);
    end
    next_cyc();
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++; $display("FAIL co_kill: got %b want 0", inst_valid);
    end
    next_cyc();
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 30'h300) begin
      errors++;
      $display("FAIL co_first: got v=%b pc=%h want v=1 pc=300",
               inst_valid, inst_pc);
    end
    repeat (8) next_cyc();
  endtask

  task automatic test_wrap_stall();
    logic [AW-1:0] nreq;
    logic [AW-1:0] hold_addr;
    bit            stalled;
    bit            saw_zero;
    int            fires;
    nreq = 30'h3fff_fffe;
    hold_addr = '0;
    stalled = 1'b0;
    saw_zero = 1'b0;
    fires = 0;
    do_reset(1, 1'b1);
    redirect = 1'b1;
    redirect_pc = 30'h3fff_fffe;
    inst_ready = 1'b1;
    push_exp(30'h3fff_fffe, 20);
    @(negedge clk);
    next_cyc();
    redirect = 1'b0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (req_addr !== hold_addr) begin
          errors++;
          $display("FAIL wr_hold: got %h want %h", req_addr, hold_addr);
        end
      end
      if (req_valid && req_ready) begin
        checks++;
        if (req_addr !== nreq) begin
          errors++; $display("FAIL wr_seq: got %h want %h", req_addr, nreq);
        end
        if (req_addr == '0) saw_zero = 1'b1;
        nreq = nreq + 1'b1;
        fires++;
      end
      stalled = req_valid && !req_ready;
      hold_addr = req_addr;
      next_cyc();
    end
    checks++;
    if (!saw_zero || fires < 3) begin
      errors++;
      $display("FAIL wr_wrap: got zero=%b fires=%0d want 1 >=3",
               saw_zero, fires);
    end
  endtask

  task automatic test_reset_midstream();
    int early;
    early = 0;
    do_reset(3, 1'b0);
    inst_ready = 1'b0;
    repeat (7) next_cyc();
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || req_valid !== 1'b0) begin
      errors++;
      $display("FAIL mr_full: got v=%b req=%b want 1 0",
               inst_valid, req_valid);
    end
    next_cyc();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (req_valid !== 1'b0) begin
      errors++; $display("FAIL mr_req_low: got %b want 0", req_valid);
    end
    next_cyc();
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0 || req_valid !== 1'b0) begin
      errors++;
      $display("FAIL mr_cleared: got v=%b req=%b want 0 0",
               inst_valid, req_valid);
    end
    next_cyc();
    exp_q.delete();
    push_exp(30'h10, 40);
    next_cyc();
    rst_n = 1'b1;
    inst_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 30'h10) begin
      errors++;
      $display("FAIL mr_restart: got v=%b a=%h want v=1 a=10",
               req_valid, req_addr);
    end
    for (int c = 1; c < 4; c++) begin
      next_cyc();
      @(negedge clk);
      if (inst_valid) early++;
    end
    checks++;
    if (early != 0) begin
      errors++; $display("FAIL mr_stale: got %0d valids want 0", early);
    end
    next_cyc();
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 30'h10) begin
      errors++;
      $display("FAIL mr_first: got v=%b pc=%h want v=1 pc=10",
               inst_valid, inst_pc);
    end
    repeat (10) next_cyc();
  endtask

  initial begin
    rst_n = 1'b0;
    inst_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_coincident();
    test_wrap_stall();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
